sonar_sweep_uc: RTL and testbench

SONAR_SWEEP_UC -- requirements
Module: sonar_sweep_uc

---
 rtl/sonar_pkg.sv | 27 ++
 rtl/sonar_contador_m.sv | 33 +++
 rtl/sonar_sweep_uc.sv | 191 +++++++++++++++++++
 tb/tb_sonar_sweep_uc.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared types and constants for the sonar sweep control unit.
// Ping-pong stepping in sonar_sweep_uc is enabled by defining SONAR_PINGPONG_EN.
package sonar_pkg;

    localparam int DB_ESTADO_W     = 4;
    localparam int N_POS_DEF       = 8;
    localparam int N_CHARS_DEF     = 8;
    localparam int MAX_RETRY_DEF   = 3;
    localparam int WAIT_CYCLES_DEF = 100000000;

    typedef enum logic [DB_ESTADO_W-1:0] {
        INICIAL   = 4'd0,
        TRIGGER   = 4'd1,
        AGUARDA   = 4'd2,
        PARTIDA   = 4'd3,
        TRANSMITE = 4'd4,
        PROX_CHAR = 4'd5,
        ESPERA    = 4'd6,
        GIRA      = 4'd7
    } estado_t;

    // Counter width for n distinct values, never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sonar_contador_m.sv
// Modulo-MODULO up/down counter with clear, enable and terminal-count flags.
module sonar_contador_m #(
    parameter int MODULO = 8,
    parameter int W      = 3
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    input  logic         down,
    output logic [W-1:0] count,
    output logic         tc_max,
    output logic         tc_min
);

    localparam logic [W-1:0] LAST = W'(MODULO - 1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            if (down) begin
                count <= (count == '0) ? LAST : count - W'(1);
            end else begin
                count <= (count == LAST) ? '0 : count + W'(1);
            end
        end
    end

    assign tc_max = (count == LAST);
    assign tc_min = (count == '0);

endmodule

// File: rtl/sonar_sweep_uc.sv
// Control unit for the sonar sweep: trigger, echo wait with retries, serial frame, dwell, step.
// Define SONAR_PINGPONG_EN to build the direction register and ping-pong stepping.
module sonar_sweep_uc
    import sonar_pkg::*;
#(
    parameter int N_POS       = N_POS_DEF,
    parameter int N_CHARS     = N_CHARS_DEF,
    parameter int MAX_RETRY   = MAX_RETRY_DEF,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          ligar,
    input  logic                          modo,
    input  logic                          pronto_medida,
    input  logic                          pronto_transmissao,
    input  logic                          timeout_echo,
    output logic                          zera,
    output logic                          medir,
    output logic                          conta_timeout_echo,
    output logic                          partida_serial,
    output logic [width_of(N_CHARS)-1:0]  char_idx,
    output logic [width_of(N_POS)-1:0]    posicao,
    output logic                          erro_medida,
    output logic                          fim_posicao,
    output logic [DB_ESTADO_W-1:0]        db_estado
);

    localparam int CW = width_of(N_CHARS);
    localparam int PW = width_of(N_POS);
    localparam int DW = width_of(WAIT_CYCLES);
    localparam int RW = width_of(MAX_RETRY + 1);

    estado_t         estado;
    estado_t         prox_estado;
    logic [RW-1:0]   retry;
    logic [DW-1:0]   dwell;
    logic            retry_inc;
    logic            erro_set;
    logic            char_en;
    logic            char_tc;
    logic            dwell_en;
    logic            dwell_tc;
    logic            gira;
    logic            step_up;
    logic            pos_tc_max;
    logic            pos_tc_min;
    logic            char_min_unused;
    logic            dwell_min_unused;

    always_ff @(posedge clock) begin
        if (reset) begin
            estado <= INICIAL;
        end else begin
            estado <= prox_estado;
        end
    end

    // Echo timeouts re-trigger until the retry budget runs out; a simultaneous echo always wins.
    always_comb begin
        prox_estado        = estado;
        zera               = 1'b0;
        medir              = 1'b0;
        conta_timeout_echo = 1'b0;
        partida_serial     = 1'b0;
        fim_posicao        = 1'b0;
        retry_inc          = 1'b0;
        erro_set           = 1'b0;
        char_en            = 1'b0;
        dwell_en           = 1'b0;
        gira               = 1'b0;
        case (estado)
            INICIAL: begin
                zera = 1'b1;
                if (ligar) prox_estado = TRIGGER;
            end
            TRIGGER: begin
                medir       = 1'b1;
                zera        = 1'b1;
                prox_estado = AGUARDA;
            end
            AGUARDA: begin
                conta_timeout_echo = 1'b1;
                if (pronto_medida) begin
                    prox_estado = PARTIDA;
                end else if (timeout_echo) begin
                    if (retry < RW'(MAX_RETRY)) begin
                        retry_inc   = 1'b1;
                        prox_estado = TRIGGER;
                    end else begin
                        erro_set    = 1'b1;
                        prox_estado = PARTIDA;
                    end
                end
            end
            PARTIDA: begin
                partida_serial = 1'b1;
                prox_estado    = TRANSMITE;
            end
            TRANSMITE: begin
                if (pronto_transmissao) prox_estado = char_tc ? ESPERA : PROX_CHAR;
            end
            PROX_CHAR: begin
                char_en     = 1'b1;
                prox_estado = PARTIDA;
            end
            ESPERA: begin
                fim_posicao = 1'b1;
                dwell_en    = !dwell_tc;
                if (dwell_tc && ligar) prox_estado = GIRA;
            end
            GIRA: begin
                gira        = 1'b1;
                prox_estado = TRIGGER;
            end
            default: prox_estado = INICIAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset || gira) begin
            retry <= '0;
        end else if (retry_inc) begin
            retry <= retry + RW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || gira) begin
            erro_medida <= 1'b0;
        end else if (erro_set) begin
            erro_medida <= 1'b1;
        end
    end

`ifdef SONAR_PINGPONG_EN
    logic dir_up;

    // Bounce off either end; modo is only looked at on the GIRA step itself.
    assign step_up = !modo || (dir_up ? !pos_tc_max : pos_tc_min);

    always_ff @(posedge clock) begin
        if (reset) begin
            dir_up <= 1'b1;
        end else if (gira && modo) begin
            dir_up <= step_up;
        end
    end
`else
    logic [2:0] pos_flags_unused;

    assign step_up          = 1'b1;
    assign pos_flags_unused = {pos_tc_max, pos_tc_min, modo};
`endif

    sonar_contador_m #(.MODULO(N_CHARS), .W(CW)) u_char (
        .clock  (clock),
        .reset  (reset),
        .clear  (gira),
        .enable (char_en),
        .down   (1'b0),
        .count  (char_idx),
        .tc_max (char_tc),
        .tc_min (char_min_unused)
    );

    sonar_contador_m #(.MODULO(N_POS), .W(PW)) u_posicao (
        .clock  (clock),
        .reset  (reset),
        .clear  (1'b0),
        .enable (gira),
        .down   (!step_up),
        .count  (posicao),
        .tc_max (pos_tc_max),
        .tc_min (pos_tc_min)
    );

    sonar_contador_m #(.MODULO(WAIT_CYCLES), .W(DW)) u_dwell (
        .clock  (clock),
        .reset  (reset),
        .clear  (gira),
        .enable (dwell_en),
        .down   (1'b0),
        .count  (dwell),
        .tc_max (dwell_tc),
        .tc_min (dwell_min_unused)
    );

    assign db_estado = estado;

endmodule

// File: tb/tb_sonar_sweep_uc.sv
// Self-checking bench for sonar_sweep_uc with a small echo/serial datapath model.
module tb_sonar_sweep_uc;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       ligar = 1'b0;
    logic       modo  = 1'b0;
    logic       pronto_medida = 1'b0;
    logic       pronto_transmissao = 1'b0;
    logic       timeout_echo = 1'b0;
    logic       zera;
    logic       medir;
    logic       conta_timeout_echo;
    logic       partida_serial;
    logic [1:0] char_idx;
    logic [1:0] posicao;
    logic       erro_medida;
    logic       fim_posicao;
    logic [3:0] db_estado;

    int total = 0;
    int bad   = 0;
    int echo_mode = 0;
    int aguarda_cnt = 0;
    int tx_cnt = 0;
    int exp_q[$];

    sonar_sweep_uc #(.N_POS(4), .N_CHARS(4), .MAX_RETRY(2), .WAIT_CYCLES(5)) dut (
        .clock              (clock),
        .reset              (reset),
        .ligar              (ligar),
        .modo               (modo),
        .pronto_medida      (pronto_medida),
        .pronto_transmissao (pronto_transmissao),
        .timeout_echo       (timeout_echo),
        .zera               (zera),
        .medir              (medir),
        .conta_timeout_echo (conta_timeout_echo),
        .partida_serial     (partida_serial),
        .char_idx           (char_idx),
        .posicao            (posicao),
        .erro_medida        (erro_medida),
        .fim_posicao        (fim_posicao),
        .db_estado          (db_estado)
    );

    always #5 clock = ~clock;

    // One cycle; on the falling edge the datapath model answers from the current state.
    task automatic step();
        @(negedge clock);
        if (db_estado == 4'd2) aguarda_cnt++; else aguarda_cnt = 0;
        if (db_estado == 4'd4) tx_cnt++; else tx_cnt = 0;
        pronto_medida = 1'b0;
        timeout_echo  = 1'b0;
        case (echo_mode)
            0: pronto_medida = (aguarda_cnt == 10);
            1: timeout_echo  = (aguarda_cnt == 6);
            default: begin
                pronto_medida = (aguarda_cnt == 4);
                timeout_echo  = (aguarda_cnt == 4);
            end
        endcase
        pronto_transmissao = (tx_cnt == 3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ligar = 1'b0;
        modo  = 1'b0;
        echo_mode = 0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ligar = 1'b1;
        step();
        step();
        total++; if (db_estado !== 4'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d want=0", db_estado); end
        total++; if (zera !== 1'b1) begin bad++; $display("[TB] FAIL reset_zera got=%b want=1", zera); end
        total++; if ({medir, conta_timeout_echo, partida_serial, fim_posicao, erro_medida} !== 5'b0) begin
            bad++; $display("[TB] FAIL reset_ctrl got=%b want=00000", {medir, conta_timeout_echo, partida_serial, fim_posicao, erro_medida});
        end
        total++; if (posicao !== 2'd0) begin bad++; $display("[TB] FAIL reset_posicao got=%0d want=0", posicao); end
        total++; if (char_idx !== 2'd0) begin bad++; $display("[TB] FAIL reset_char got=%0d want=0", char_idx); end
        reset = 1'b0;
        ligar = 1'b0;
        for (int i = 0; i < 3; i++) step();
        total++; if (db_estado !== 4'd0) begin bad++; $display("[TB] FAIL idle_hold got=%0d want=0", db_estado); end
        ligar = 1'b1;
        step();
        total++; if (db_estado !== 4'd1 || medir !== 1'b1 || zera !== 1'b1) begin
            bad++; $display("[TB] FAIL start_trigger got=%0d/%b/%b want=1/1/1", db_estado, medir, zera);
        end
        step();
        total++; if (db_estado !== 4'd2 || conta_timeout_echo !== 1'b1 || medir !== 1'b0) begin
            bad++; $display("[TB] FAIL aguarda_out got=%0d/%b/%b want=2/1/0", db_estado, conta_timeout_echo, medir);
        end
    endtask

    task automatic test_frame();
        int medir_n = 0;
        int guard = 0;
        int e;
        do_reset();
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        ligar = 1'b1;
        while (fim_posicao !== 1'b1 && guard < 300) begin
            step();
            guard++;
            if (medir === 1'b1) medir_n++;
            if (partida_serial === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("[TB] FAIL frame_extra_partida got=char%0d want=none", char_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (char_idx !== 2'(e)) begin bad++; $display("[TB] FAIL frame_char got=%0d want=%0d", char_idx, e); end
                end
            end
        end
        total++; if (guard >= 300) begin bad++; $display("[TB] FAIL frame_timeout got=%0d cycles want<300", guard); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL frame_missing got=%0d left want=0", exp_q.size()); end
        total++; if (medir_n != 1) begin bad++; $display("[TB] FAIL frame_medir got=%0d want=1", medir_n); end
        total++; if (db_estado !== 4'd6 || erro_medida !== 1'b0) begin
            bad++; $display("[TB] FAIL frame_end got=%0d/%b want=6/0", db_estado, erro_medida);
        end
    endtask

    task automatic test_retry();
        int medir_n = 0;
        int guard = 0;
        int e;
        do_reset();
        echo_mode = 1;
        for (int i = 0; i < 4; i++) exp_q.push_back(i);
        ligar = 1'b1;
        while (fim_posicao !== 1'b1 && guard < 400) begin
            step();
            guard++;
            if (medir === 1'b1) medir_n++;
            if (partida_serial === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("[TB] FAIL retry_extra_partida got=char%0d want=none", char_idx);
                end else begin
                    e = exp_q.pop_front();
                    if (char_idx !== 2'(e) || erro_medida !== 1'b1) begin
                        bad++; $display("[TB] FAIL retry_char got=%0d/erro%b want=%0d/erro1", char_idx, erro_medida, e);
                    end
                end
            end
        end
        total++; if (guard >= 400) begin bad++; $display("[TB] FAIL retry_timeout got=%0d cycles want<400", guard); end
        total++; if (medir_n != 3) begin bad++; $display("[TB] FAIL retry_medir got=%0d want=3", medir_n); end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL retry_missing got=%0d left want=0", exp_q.size()); end
        total++; if (erro_medida !== 1'b1) begin bad++; $display("[TB] FAIL retry_erro_held got=%b want=1", erro_medida); end
        echo_mode = 0;
        guard = 0;
        while (db_estado !== 4'd1 && guard < 50) begin step(); guard++; end
        total++; if (erro_medida !== 1'b0 || posicao !== 2'd1 || guard >= 50) begin
            bad++; $display("[TB] FAIL retry_gira_clear got=erro%b/pos%0d want=erro0/pos1", erro_medida, posicao);
        end
    endtask

    task automatic test_both();
        int guard = 0;
        do_reset();
        echo_mode = 2;
        ligar = 1'b1;
        while (!(db_estado === 4'd2 && pronto_medida === 1'b1 && timeout_echo === 1'b1) && guard < 50) begin
            step(); guard++;
        end
        total++; if (guard >= 50) begin bad++; $display("[TB] FAIL both_setup got=%0d cycles want<50", guard); end
        step();
        total++; if (db_estado !== 4'd3 || partida_serial !== 1'b1) begin
            bad++; $display("[TB] FAIL both_next got=%0d/%b want=3/1", db_estado, partida_serial);
        end
        total++; if (erro_medida !== 1'b0) begin bad++; $display("[TB] FAIL both_erro got=%b want=0", erro_medida); end
        total++; if (dut.retry !== 2'd0) begin bad++; $display("[TB] FAIL both_retry got=%0d want=0", dut.retry); end
        echo_mode = 0;
    endtask

    task automatic test_sweep();
        int guard = 0;
        int e;
        do_reset();
        modo = 1'b1;
`ifdef SONAR_PINGPONG_EN
        exp_q = '{0, 1, 2, 3, 2, 1, 0, 1};
`else
        exp_q = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
        ligar = 1'b1;
        while (exp_q.size() != 0 && guard < 1500) begin
            step();
            guard++;
            if (medir === 1'b1) begin
                e = exp_q.pop_front();
                total++;
                if (posicao !== 2'(e)) begin bad++; $display("[TB] FAIL sweep_pos got=%0d want=%0d", posicao, e); end
            end
        end
        total++; if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL sweep_timeout got=%0d left want=0", exp_q.size()); end
        modo = 1'b0;
    endtask

    task automatic test_ligar_drop();
        int guard = 0;
        int partidas = 0;
        int not_espera = 0;
        int esp = 0;
        do_reset();
        ligar = 1'b1;
        while (db_estado !== 4'd4 && guard < 100) begin
            step(); guard++;
            if (partida_serial === 1'b1) partidas++;
        end
        ligar = 1'b0;
        while (fim_posicao !== 1'b1 && guard < 300) begin
            step(); guard++;
            if (partida_serial === 1'b1) partidas++;
        end
        total++; if (partidas != 4 || guard >= 300) begin
            bad++; $display("[TB] FAIL drop_frame got=%0d partidas want=4", partidas);
        end
        for (int i = 0; i < 12; i++) begin
            step();
            if (db_estado !== 4'd6) not_espera++;
        end
        total++; if (not_espera != 0) begin bad++; $display("[TB] FAIL drop_hold got=%0d left want=0", not_espera); end
        ligar = 1'b1;
        step();
        total++; if (db_estado !== 4'd7) begin bad++; $display("[TB] FAIL drop_resume got=%0d want=7", db_estado); end
        guard = 0;
        while (fim_posicao !== 1'b1 && guard < 300) begin step(); guard++; end
        while (db_estado === 4'd6 && esp < 20) begin esp++; step(); end
        total++; if (esp != 5 || db_estado !== 4'd7) begin
            bad++; $display("[TB] FAIL dwell_len got=%0d cycles/st%0d want=5/st7", esp, db_estado);
        end
    endtask

    task automatic test_reset_mid();
        int guard = 0;
        do_reset();
        ligar = 1'b1;
        while (!(posicao === 2'd2 && db_estado === 4'd4 && char_idx === 2'd2) && guard < 600) begin
            step(); guard++;
        end
        total++; if (guard >= 600) begin bad++; $display("[TB] FAIL mid_setup got=%0d cycles want<600", guard); end
        reset = 1'b1;
        step();
        total++; if (db_estado !== 4'd0 || posicao !== 2'd0 || char_idx !== 2'd0) begin
            bad++; $display("[TB] FAIL mid_reset got=%0d/%0d/%0d want=0/0/0", db_estado, posicao, char_idx);
        end
        total++; if (zera !== 1'b1 || partida_serial !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_reset_out got=%b/%b want=1/0", zera, partida_serial);
        end
        reset = 1'b0;
        ligar = 1'b0;
    endtask

    initial begin
        test_reset();
        test_frame();
        test_retry();
        test_both();
        test_sweep();
        test_ligar_drop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
